// File: rtl/binary_query_driver.sv
// Transmit-side sequencer for the binarized attention value stage.
// Streams T upstream steps into the binary query block, then collects
// the T sign results it returns, tagging each with its step index.
module binary_query_driver #(
  parameter int T        = 30,
  parameter int VW       = 30,
  parameter int NV       = 16,
  parameter int NS       = 4,
  parameter int DRAIN_TO = 8,
  parameter int CW       = $clog2(T+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             step_valid,
  output logic             step_ready,
  input  logic [NV*VW-1:0] step_value,
  input  logic [NS*VW-1:0] step_score,
  output logic [NV*VW-1:0] value_out,
  output logic [NS*VW-1:0] score_out,
  output logic             q_valid,
  input  logic [NV-1:0]    q_data,
  input  logic             q_data_valid,
  output logic [NV-1:0]    res_data,
  output logic [CW-1:0]    res_idx,
  output logic             res_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // state   | meaning
  // S_IDLE  | waiting for start; any result arriving here is an error
  // S_STREAM| accepting up to T steps, results counted as they return
  // S_DRAIN | all steps sent, waiting for remaining results or timeout
  // S_DONE  | one cycle before the done pulse, then back to idle
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  localparam int            IW   = $clog2(DRAIN_TO+1);
  localparam logic [CW-1:0] T_C  = CW'(T);
  localparam logic [IW-1:0] TO_C = IW'(DRAIN_TO);

  state_t             r_state;
  logic [CW-1:0]      r_sent_cnt;
  logic [CW-1:0]      r_rcv_cnt;
  logic [IW-1:0]      r_idle_cnt;
  logic [NV*VW-1:0]   r_value_out;
  logic [NS*VW-1:0]   r_score_out;
  logic               r_q_valid;
  logic [NV-1:0]      r_res_data;
  logic [CW-1:0]      r_res_idx;
  logic               r_res_valid;
  logic               r_done;
  logic               r_err;

  logic w_active;
  logic w_hs;
  logic w_res_ok;

  // Results are only accepted while a run is active and not already full.
  assign w_active   = (r_state == S_STREAM) || (r_state == S_DRAIN);
  assign step_ready = (r_state == S_STREAM) && (r_sent_cnt < T_C);
  assign w_hs       = step_valid && step_ready;
  assign w_res_ok   = q_data_valid && w_active && (r_rcv_cnt != T_C);

  assign value_out = r_value_out;
  assign score_out = r_score_out;
  assign q_valid   = r_q_valid;
  assign res_data  = r_res_data;
  assign res_idx   = r_res_idx;
  assign res_valid = r_res_valid;
  assign busy      = w_active;
  assign done      = r_done;
  assign err       = r_err;

  // Sequencer: step streaming, result collection, drain timeout, abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sent_cnt  <= '0;
      r_rcv_cnt   <= '0;
      r_idle_cnt  <= '0;
      r_value_out <= '0;
      r_score_out <= '0;
      r_q_valid   <= 1'b0;
      r_res_data  <= '0;
      r_res_idx   <= '0;
      r_res_valid <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_q_valid   <= 1'b0;
      r_res_valid <= 1'b0;
      r_done      <= 1'b0;
      if (abort) begin
        r_state    <= S_IDLE;
        r_sent_cnt <= '0;
        r_rcv_cnt  <= '0;
        r_idle_cnt <= '0;
      end else begin
        if (w_hs) begin
          r_value_out <= step_value;
          r_score_out <= step_score;
          r_q_valid   <= 1'b1;
          r_sent_cnt  <= r_sent_cnt + CW'(1);
        end
        if (w_res_ok) begin
          r_res_data  <= q_data;
          r_res_idx   <= r_rcv_cnt;
          r_res_valid <= 1'b1;
          r_rcv_cnt   <= r_rcv_cnt + CW'(1);
          r_idle_cnt  <= '0;
        end else if (q_data_valid) begin
          r_err <= 1'b1;
        end
        case (r_state)
          S_IDLE: begin
            // A start clears err even if a stray result lands in the same cycle.
            if (start) begin
              r_state    <= S_STREAM;
              r_sent_cnt <= '0;
              r_rcv_cnt  <= '0;
              r_idle_cnt <= '0;
              r_err      <= 1'b0;
            end
          end
          S_STREAM: begin
            if (r_sent_cnt == T_C) r_state <= S_DRAIN;
          end
          S_DRAIN: begin
            if (r_rcv_cnt == T_C) begin
              r_state <= S_DONE;
            end else if (r_idle_cnt == TO_C) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else if (!q_data_valid) begin
              r_idle_cnt <= r_idle_cnt + IW'(1);
            end
          end
          S_DONE: begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
